// File: rtl/sys_launcher.sv
// Job launcher for a systolic GEMM array: accepts a dimension descriptor, checks it,
// runs the controller with a timeout, then holds a result until the consumer takes it.
module sys_launcher #(
    parameter int SYS_ARR_SIZE = 8,
    parameter int INTEGER_BIT  = 8,
    parameter int TIMEOUT      = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [INTEGER_BIT-1:0] cmd_m,
    input  logic [INTEGER_BIT-1:0] cmd_k,
    input  logic [INTEGER_BIT-1:0] cmd_n,
    input  logic                   cmd_ws_os,
    output logic                   ctrl_enable,
    input  logic                   ctrl_finish,
    output logic [INTEGER_BIT-1:0] ctrl_m,
    output logic [INTEGER_BIT-1:0] ctrl_k,
    output logic [INTEGER_BIT-1:0] ctrl_n,
    output logic                   ctrl_ws_os,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [1:0]             resp_err,
    output logic [15:0]            resp_cycles,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [INTEGER_BIT:0] MAX_DIM     = (INTEGER_BIT + 1)'(SYS_ARR_SIZE);
    localparam logic [15:0]          TIMEOUT_VAL = 16'(TIMEOUT);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIM     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    state_t      state;
    state_t      next_state;
    logic [15:0] cycle_cnt;
    logic [15:0] cnt_inc;
    logic        accept;
    logic        cmd_bad;
    logic        timed_out;

    function automatic logic dim_bad(input logic [INTEGER_BIT-1:0] d);
        return (d == '0) || ({1'b0, d} > MAX_DIM);
    endfunction

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = cmd_valid & cmd_ready;
    assign cmd_bad    = dim_bad(cmd_m) | dim_bad(cmd_k) | dim_bad(cmd_n);

    // cnt_inc is the number of enabled cycles including the current RUN cycle.
    assign cnt_inc   = (cycle_cnt == 16'hFFFF) ? cycle_cnt : cycle_cnt + 16'd1;
    assign timed_out = (cnt_inc == TIMEOUT_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = cmd_bad ? RESP : RUN;
                end
            end
            RUN: begin
                if (ctrl_finish || timed_out) begin
                    next_state = CLEAR;
                end
            end
            // Wait for the controller to drop finish so its next job restarts from zero.
            CLEAR: begin
                if (!ctrl_finish) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_enable <= 1'b0;
            ctrl_m      <= '0;
            ctrl_k      <= '0;
            ctrl_n      <= '0;
            ctrl_ws_os  <= 1'b0;
            cycle_cnt   <= 16'd0;
            resp_err    <= ERR_OK;
            resp_cycles <= 16'd0;
        end else begin
            ctrl_enable <= (next_state == RUN);
            if (accept) begin
                ctrl_m     <= cmd_m;
                ctrl_k     <= cmd_k;
                ctrl_n     <= cmd_n;
                ctrl_ws_os <= cmd_ws_os;
                cycle_cnt  <= 16'd0;
                if (cmd_bad) begin
                    resp_err    <= ERR_DIM;
                    resp_cycles <= 16'd0;
                end
            end
            if (state == RUN) begin
                cycle_cnt <= cnt_inc;
                if (next_state == CLEAR) begin
                    resp_cycles <= cnt_inc;
                    resp_err    <= ctrl_finish ? ERR_OK : ERR_TIMEOUT;
                end
            end
        end
    end

endmodule

// File: tb/tb_sys_launcher.sv
// Scoreboard bench for sys_launcher: a job-level model predicts each response, a
// controller model drives finish, and a monitor pops and checks every response.
module tb_sys_launcher;

    localparam int ARR = 8;
    localparam int IB  = 8;
    localparam int TO  = 30;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IB-1:0] cmd_m;
    logic [IB-1:0] cmd_k;
    logic [IB-1:0] cmd_n;
    logic          cmd_ws_os;
    logic          ctrl_enable;
    logic          ctrl_finish;
    logic [IB-1:0] ctrl_m;
    logic [IB-1:0] ctrl_k;
    logic [IB-1:0] ctrl_n;
    logic          ctrl_ws_os;
    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_err;
    logic [15:0]   resp_cycles;
    logic          busy;

    typedef struct {
        int m;
        int k;
        int n;
        int ws;
        int fin_at;
        int linger;
        int delay;
        int err;
        int cycles;
    } job_t;

    job_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    sys_launcher #(
        .SYS_ARR_SIZE(ARR),
        .INTEGER_BIT (IB),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_m      (cmd_m),
        .cmd_k      (cmd_k),
        .cmd_n      (cmd_n),
        .cmd_ws_os  (cmd_ws_os),
        .ctrl_enable(ctrl_enable),
        .ctrl_finish(ctrl_finish),
        .ctrl_m     (ctrl_m),
        .ctrl_k     (ctrl_k),
        .ctrl_n     (ctrl_n),
        .ctrl_ws_os (ctrl_ws_os),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_err   (resp_err),
        .resp_cycles(resp_cycles),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Job-level reference: a bad dimension never runs, otherwise the earlier of
    // finish and timeout ends the job, and finish wins a tie.
    function automatic job_t makeJob(input int m, input int k, input int n, input int ws,
                                     input int fin_at, input int linger, input int delay);
        job_t j;
        j.m = m; j.k = k; j.n = n; j.ws = ws;
        j.fin_at = fin_at; j.linger = linger; j.delay = delay;
        if (m < 1 || m > ARR || k < 1 || k > ARR || n < 1 || n > ARR) begin
            j.err = 1; j.cycles = 0;
        end else if (fin_at >= 1 && fin_at <= TO) begin
            j.err = 0; j.cycles = fin_at;
        end else begin
            j.err = 2; j.cycles = TO;
        end
        return j;
    endfunction

    task automatic applyStimulus(input int m, input int k, input int n, input int ws,
                                 input int fin_at, input int linger, input int delay);
        int   guard = 0;
        logic ready_now;
        cmd_m     = IB'(m);
        cmd_k     = IB'(k);
        cmd_n     = IB'(n);
        cmd_ws_os = ws[0];
        cmd_valid = 1'b1;
        exp_q.push_back(makeJob(m, k, n, ws, fin_at, linger, delay));
        ready_now = cmd_ready;
        while (!ready_now && guard < 400) begin
            @(posedge clk); #1;
            ready_now = cmd_ready;
            guard++;
        end
        checkOutput("cmd_accept", int'(ready_now), 1);
        if (!ready_now) begin
            cmd_valid = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_m     = IB'($urandom);
        cmd_k     = IB'($urandom);
        cmd_n     = IB'($urandom);
        cmd_ws_os = 1'($urandom);
        checkOutput("cmd_ready_after_accept", int'(cmd_ready), 0);
        checkOutput("busy_after_accept", int'(busy), 1);
        checkOutput("ctrl_m_latch", int'(ctrl_m), m);
        checkOutput("ctrl_k_latch", int'(ctrl_k), k);
        checkOutput("ctrl_n_latch", int'(ctrl_n), n);
        checkOutput("ctrl_ws_latch", int'(ctrl_ws_os), ws);
    endtask

    task automatic waitDrain();
        int guard = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("drain", int'(exp_q.size() == 0 && cmd_ready), 1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ctrl_enable"}, int'(ctrl_enable), 0);
        checkOutput({tag, "_resp_valid"}, int'(resp_valid), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        checkOutput({tag, "_resp_err"}, int'(resp_err), 0);
        checkOutput({tag, "_resp_cycles"}, int'(resp_cycles), 0);
        checkOutput({tag, "_ctrl_m"}, int'(ctrl_m), 0);
        checkOutput({tag, "_ctrl_ws"}, int'(ctrl_ws_os), 0);
    endtask

    // Controller model: raise finish during the job's fin_at-th enabled cycle and
    // keep it high for 'linger' cycles after enable drops.
    initial begin
        int en_cycles   = 0;
        int linger_left = 0;
        ctrl_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_cycles   = 0;
                ctrl_finish = 1'b0;
            end else if (ctrl_enable) begin
                if (en_cycles == 0) checkOutput("enable_rise_with_finish", int'(ctrl_finish), 0);
                en_cycles++;
                if (exp_q.size() > 0 && exp_q[0].fin_at == en_cycles) begin
                    ctrl_finish = 1'b1;
                    linger_left = exp_q[0].linger;
                end
            end else begin
                en_cycles = 0;
                if (ctrl_finish) begin
                    if (linger_left == 0) ctrl_finish = 1'b0;
                    else linger_left--;
                end
            end
        end
    end

    // Monitor and responder: check each response on arrival, its stability while
    // held, and the handshake aftermath; drive resp_ready with the job's delay.
    initial begin
        bit          in_resp  = 0;
        int          wait_cnt = 0;
        int          en_count = 0;
        job_t        cur;
        logic [1:0]  held_err = '0;
        logic [15:0] held_cyc = '0;
        cur.delay  = 0;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_resp    = 0;
                en_count   = 0;
                resp_ready = 1'b0;
            end else begin
                if (ctrl_enable) en_count++;
                if (resp_valid) begin
                    if (!in_resp) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("[TB] FAIL unexpected_resp: got resp_valid=1 expected no response");
                            cur.delay = 0;
                        end else begin
                            cur = exp_q.pop_front();
                            checkOutput("resp_err", int'(resp_err), cur.err);
                            checkOutput("resp_cycles", int'(resp_cycles), cur.cycles);
                            checkOutput("enable_cycles", en_count, cur.cycles);
                            checkOutput("ctrl_m_hold", int'(ctrl_m), cur.m);
                            checkOutput("ctrl_k_hold", int'(ctrl_k), cur.k);
                            checkOutput("ctrl_n_hold", int'(ctrl_n), cur.n);
                            checkOutput("ctrl_ws_hold", int'(ctrl_ws_os), cur.ws);
                        end
                        in_resp  = 1;
                        wait_cnt = 0;
                        en_count = 0;
                        held_err = resp_err;
                        held_cyc = resp_cycles;
                    end else begin
                        checkOutput("resp_err_stable", int'(resp_err), int'(held_err));
                        checkOutput("resp_cycles_stable", int'(resp_cycles), int'(held_cyc));
                        wait_cnt++;
                    end
                    checkOutput("cmd_ready_in_resp", int'(cmd_ready), 0);
                    resp_ready = (wait_cnt >= cur.delay);
                end else begin
                    if (in_resp) begin
                        checkOutput("cmd_ready_after_resp", int'(cmd_ready), 1);
                        checkOutput("busy_after_resp", int'(busy), 0);
                        in_resp = 0;
                    end
                    resp_ready = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion expected test end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        int guard;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_m     = '0;
        cmd_k     = '0;
        cmd_n     = '0;
        cmd_ws_os = 1'b0;
        #3;
        checkResetState("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(4, 3, 5, 0, 25, 2, 1);
        applyStimulus(4, 0, 5, 1, 5, 0, 0);
        applyStimulus(3, 3, 9, 0, 5, 0, 2);
        applyStimulus(8, 8, 8, 1, 5, 0, 0);
        applyStimulus(1, 1, 1, 0, 1, 0, 0);
        applyStimulus(2, 2, 2, 0, 0, 0, 1);
        applyStimulus(5, 1, 7, 1, TO, 1, 0);
        applyStimulus(6, 2, 3, 0, TO + 1, 0, 0);

        // A long-held response while a second command waits with cmd_valid high.
        applyStimulus(6, 6, 6, 1, 8, 1, 10);
        applyStimulus(2, 7, 3, 0, 4, 0, 0);
        waitDrain();

        for (int i = 0; i < 14; i++) begin
            int fin;
            fin = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TO + 4));
            applyStimulus(int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                          int'($urandom_range(0, 10)), int'($urandom_range(0, 1)),
                          fin, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end
        waitDrain();

        // Reset in the middle of a run: the job vanishes and the next one is normal.
        applyStimulus(5, 2, 7, 1, 0, 0, 0);
        seen  = 0;
        guard = 0;
        while (seen < 7 && guard < 100) begin
            @(negedge clk);
            if (ctrl_enable) seen++;
            guard++;
        end
        checkOutput("run_cycles_before_reset", seen, 7);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checkResetState("mid_run_reset");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("no_resp_after_reset", int'(resp_valid), 0);
        end
        applyStimulus(3, 4, 2, 0, 9, 1, 2);
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
